// File: rtl/digital_fll_controller_if.sv
// Control/status bundle between the FLL controller and its surroundings.
// slave = controller side, master = system/testbench side.
interface digital_fll_controller_if #(
  parameter int unsigned TRIM_W = 26,
  parameter int unsigned DIV_W  = 5,
  parameter int unsigned CNT_W  = 8
);
  logic              enable;
  logic              osc;
  logic [DIV_W-1:0]  div;
  logic              dco_mode;
  logic [TRIM_W-1:0] ext_trim;
  logic [TRIM_W-1:0] trim;
  logic              locked;
  logic              meas_valid;
  logic [CNT_W-1:0]  meas_count;

  modport master (
    output enable, osc, div, dco_mode, ext_trim,
    input  trim, locked, meas_valid, meas_count
  );

  modport slave (
    input  enable, osc, div, dco_mode, ext_trim,
    output trim, locked, meas_valid, meas_count
  );
endinterface

// File: rtl/digital_fll_controller.sv
// Frequency-locked-loop controller: counts DCO cycles per reference period and
// steps a thermometer trim code toward the target ratio, with lock detection.
module digital_fll_controller #(
  parameter int unsigned TRIM_W    = 26,
  parameter int unsigned DIV_W     = 5,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned TOL       = 1,
  parameter int unsigned LOCK_N    = 4,
  parameter int unsigned INIT_CODE = 13
) (
  input logic                      clock,
  input logic                      reset,
  digital_fll_controller_if.slave  bus
);

  localparam int unsigned CODE_W = $clog2(TRIM_W + 1);
  localparam int unsigned STRK_W = $clog2(LOCK_N + 1);

  localparam logic [CODE_W-1:0] CODE_MAX  = CODE_W'(TRIM_W);
  localparam logic [CODE_W-1:0] CODE_INIT = CODE_W'(INIT_CODE);
  localparam logic [STRK_W-1:0] STRK_MAX  = STRK_W'(LOCK_N);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]    TOL_EXT   = (CNT_W + 1)'(TOL);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StArm   = 2'd1;
  localparam logic [1:0] StTrack = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              s1_q, s2_q, s3_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [STRK_W-1:0] streak_q, streak_d;
  logic              locked_q, locked_d;
  logic              meas_valid_q, meas_valid_d;
  logic [CNT_W-1:0]  meas_count_q, meas_count_d;
  logic [DIV_W-1:0]  div_q;

  logic              osc_edge;
  logic              div_chg;
  logic [CNT_W:0]    div_ext, win_lo, win_hi, m_ext;
  logic [TRIM_W-1:0] therm;

  assign osc_edge = s2_q & ~s3_q;
  assign div_chg  = (bus.div != div_q);

  // Window is computed one bit wider than the counter so div+TOL cannot wrap.
  assign div_ext = (CNT_W + 1)'(bus.div);
  assign win_lo  = (div_ext > TOL_EXT) ? (div_ext - TOL_EXT) : '0;
  assign win_hi  = div_ext + TOL_EXT;
  assign m_ext   = {1'b0, cnt_q};

  always_comb begin
    therm = '0;
    for (int i = 0; i < int'(TRIM_W); i++) begin
      therm[i] = (i < int'(code_q));
    end
  end

  assign bus.trim       = bus.dco_mode ? bus.ext_trim : therm;
  assign bus.locked     = locked_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.meas_count = meas_count_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    code_d       = code_q;
    streak_d     = streak_q;
    locked_d     = locked_q;
    meas_valid_d = 1'b0;
    meas_count_d = meas_count_q;

    if (!bus.enable || bus.dco_mode) begin
      state_d  = StIdle;
      cnt_d    = '0;
      streak_d = '0;
      locked_d = 1'b0;
      if (!bus.enable) code_d = CODE_INIT;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StArm;
          cnt_d   = '0;
        end
        StArm: begin
          // First edge only aligns the counter to the reference period.
          if (osc_edge && !div_chg) begin
            state_d = StTrack;
            cnt_d   = CNT_ONE;
          end
        end
        StTrack: begin
          if (div_chg) begin
            state_d  = StArm;
            cnt_d    = '0;
            streak_d = '0;
            locked_d = 1'b0;
          end else if (osc_edge) begin
            meas_valid_d = 1'b1;
            meas_count_d = cnt_q;
            cnt_d        = CNT_ONE;
            if (bus.div == '0) begin
              streak_d = '0;
              locked_d = 1'b0;
            end else if (m_ext > win_hi) begin
              if (code_q != CODE_MAX) code_d = code_q + CODE_W'(1);
              streak_d = '0;
              locked_d = 1'b0;
            end else if (m_ext < win_lo) begin
              if (code_q != '0) code_d = code_q - CODE_W'(1);
              streak_d = '0;
              locked_d = 1'b0;
            end else begin
              streak_d = (streak_q == STRK_MAX) ? streak_q : streak_q + STRK_W'(1);
              locked_d = (streak_d == STRK_MAX);
            end
            if (cnt_q == CNT_MAX) begin
              streak_d = '0;
              locked_d = 1'b0;
            end
          end else begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
            // A stalled reference must not leave a stale lock indication.
            if (cnt_d == CNT_MAX) begin
              streak_d = '0;
              locked_d = 1'b0;
            end
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      cnt_q        <= '0;
      code_q       <= CODE_INIT;
      streak_q     <= '0;
      locked_q     <= 1'b0;
      meas_valid_q <= 1'b0;
      meas_count_q <= '0;
    end else begin
      state_q      <= state_d;
      s1_q         <= bus.osc;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      cnt_q        <= cnt_d;
      code_q       <= code_d;
      streak_q     <= streak_d;
      locked_q     <= locked_d;
      meas_valid_q <= meas_valid_d;
      meas_count_q <= meas_count_d;
    end
  end

  always_ff @(posedge clock) begin
    div_q <= bus.div;
  end

endmodule

// File: tb/tb_digital_fll_controller.sv
// Directed self-checking bench for digital_fll_controller (default parameters).
module tb_digital_fll_controller;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  // Reference oscillator model: period in clocks, changes only at a rising edge.
  bit   osc_run;
  int   per_next;
  int   per;
  int   ph;

  digital_fll_controller_if #(.TRIM_W(26), .DIV_W(5), .CNT_W(8)) bus ();

  digital_fll_controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    bus.osc = 1'b0;
    ph      = 0;
    per     = 10;
    forever begin
      @(posedge clock);
      #1;
      if (!osc_run) begin
        bus.osc = 1'b0;
        ph      = 0;
        per     = per_next;
      end else begin
        bus.osc = (ph < per / 2);
        ph++;
        if (ph >= per) begin
          ph  = 0;
          per = per_next;
        end
      end
    end
  end

  function automatic logic [25:0] therm(input int c);
    logic [25:0] t;
    for (int i = 0; i < 26; i++) t[i] = (i < c);
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the next meas_valid pulse, then check the cycle's results.
  task automatic meas(input string tag, input int m, input int code, input bit lk);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus.meas_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout: observed no meas_valid expected pulse", tag);
    end else begin
      chk({tag, "_count"}, 32'(bus.meas_count), 32'(m));
      chk({tag, "_trim"}, 32'(bus.trim), 32'(therm(code)));
      chk({tag, "_locked"}, 32'(bus.locked), 32'(lk));
    end
  endtask

  initial begin
    int n;
    bit saw;
    checks       = 0;
    errors       = 0;
    osc_run      = 1'b0;
    per_next     = 10;
    reset        = 1'b1;
    bus.enable   = 1'b0;
    bus.div      = 5'd8;
    bus.dco_mode = 1'b0;
    bus.ext_trim = '0;
    repeat (3) @(negedge clock);
    chk("reset_trim", 32'(bus.trim), 32'h0001FFF);
    chk("reset_locked", 32'(bus.locked), 0);
    chk("reset_valid", 32'(bus.meas_valid), 0);
    chk("reset_count", 32'(bus.meas_count), 0);
    reset = 1'b0;

    // Slow DCO: period 10 > hi=9, code climbs to 26 and saturates.
    bus.enable = 1'b1;
    osc_run    = 1'b1;
    for (int k = 1; k <= 15; k++) meas("p10", 10, (13 + k > 26) ? 26 : 13 + k, 1'b0);
    chk("p10_full_trim", 32'(bus.trim), 32'h3FFFFFF);

    // Fast DCO: period 5 < lo=7, code falls to 0 and saturates.
    per_next = 5;
    meas("p10_tail", 10, 26, 1'b0);
    for (int k = 1; k <= 28; k++) meas("p5", 5, (26 - k < 0) ? 0 : 26 - k, 1'b0);

    // Period 7 at the low window edge: held, lock after 4.
    per_next = 7;
    meas("p5_tail", 5, 0, 1'b0);
    for (int k = 1; k <= 4; k++) meas("p7", 7, 0, k == 4);
    per_next = 8;
    meas("p7_tail", 7, 0, 1'b1);
    for (int k = 1; k <= 2; k++) meas("p8a", 8, 0, 1'b1);

    // Period 11 breaks lock and raises code in the same cycle.
    per_next = 11;
    meas("p8a_tail", 8, 0, 1'b1);
    meas("p11", 11, 1, 1'b0);
    per_next = 8;
    meas("p11_tail", 11, 2, 1'b0);
    for (int k = 1; k <= 4; k++) meas("p8b", 8, 2, k == 4);
    @(negedge clock);
    chk("valid_one_cycle", 32'(bus.meas_valid), 0);

    // DCO override: trim follows ext_trim combinationally, loop frozen.
    bus.dco_mode = 1'b1;
    bus.ext_trim = 26'h2AAAAAA;
    #1;
    chk("dco_trim", 32'(bus.trim), 32'h2AAAAAA);
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.meas_valid === 1'b1) saw = 1'b1;
    end
    chk("dco_locked", 32'(bus.locked), 0);
    chk("dco_no_valid", 32'(saw), 0);
    bus.dco_mode = 1'b0;
    #1;
    chk("dco_ret_trim", 32'(bus.trim), 32'(therm(2)));
    for (int k = 1; k <= 4; k++) meas("p8c", 8, 2, k == 4);

    // Reference stops while locked: lock drops when the counter reaches 255.
    osc_run = 1'b0;
    n = 0;
    saw = 1'b0;
    while (bus.locked === 1'b1 && n < 400) begin
      @(negedge clock);
      if (bus.meas_valid === 1'b1) saw = 1'b1;
      n++;
    end
    chk("stall_cycles", 32'(n), 254);
    chk("stall_no_valid", 32'(saw), 0);
    chk("stall_count", 32'(bus.meas_count), 8);

    // div = 0: measurements reported, code never moves.
    bus.div = 5'd0;
    osc_run = 1'b1;
    for (int k = 1; k <= 3; k++) meas("div0", 8, 2, 1'b0);

    // Reset mid-measurement restores everything next cycle.
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rst2_trim", 32'(bus.trim), 32'h0001FFF);
    chk("rst2_locked", 32'(bus.locked), 0);
    chk("rst2_valid", 32'(bus.meas_valid), 0);
    chk("rst2_count", 32'(bus.meas_count), 0);
    reset = 1'b0;
    @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
